// File: rtl/jb_aes_pkg.sv
// Shared AES types and constants: block/word types, expander FSM states, rcon table, and the S-box.
// The S-box constant is also consumed by the SubBytes stage of the encrypt datapath.
package jb_aes_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NUM_RK  = 11;
  localparam int unsigned CNT_W   = 4;

  typedef logic [BLOCK_W-1:0] block128_t;
  typedef logic [WORD_W-1:0]  word32_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  // Entry 0 is unused; round n uses RCON[n].
  localparam logic [7:0] RCON [NUM_RK] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic word32_t rot_word(input word32_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/jb_aes_sbox_word.sv
// SubWord: four parallel S-box byte lookups on a 32-bit word.
module jb_aes_sbox_word
  import jb_aes_pkg::*;
(
  input  logic [31:0] in_word,
  output logic [31:0] out_word_c
);

  assign out_word_c = {SBOX[in_word[31:24]], SBOX[in_word[23:16]],
                       SBOX[in_word[15:8]],  SBOX[in_word[7:0]]};

endmodule

// File: rtl/jb_aes128_key_expander.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry register file,
// with a combinational indexed read port for the encrypt datapath.
module jb_aes128_key_expander
  import jb_aes_pkg::*;
#(
  parameter int unsigned NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         keys_valid,
  output logic         done,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  if (NROUNDS != 10) begin : g_bad_nrounds
    $error("jb_aes128_key_expander supports only NROUNDS=10");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NROUNDS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  block128_t          rk_q [NUM_RK];
  block128_t          rk_d [NUM_RK];
  logic               busy_q, busy_d;
  logic               keys_valid_q, keys_valid_d;
  logic               done_q, done_d;

  block128_t          prev_key;
  block128_t          next_key;
  logic [7:0]         rcon;
  word32_t            sub_word;
  word32_t            t_word;
  word32_t            n0, n1, n2, n3;
  logic [CNT_W-1:0]   prev_idx;

  // Previous key and rcon for the round being produced; guarded so idle counts never index out of range.
  always_comb begin
    prev_idx = cnt_q - CNT_W'(1);
    prev_key = '0;
    rcon     = 8'h00;
    for (int i = 0; i < NUM_RK; i++) begin
      if (CNT_W'(i) == prev_idx) prev_key = rk_q[i];
      if (CNT_W'(i) == cnt_q)    rcon     = RCON[i];
    end
  end

  jb_aes_sbox_word u_sbox_word (
    .in_word    (rot_word(prev_key[31:0])),
    .out_word_c (sub_word)
  );

  always_comb begin
    t_word   = sub_word ^ {rcon, 24'h0};
    n0       = prev_key[127:96] ^ t_word;
    n1       = prev_key[95:64]  ^ n0;
    n2       = prev_key[63:32]  ^ n1;
    n3       = prev_key[31:0]   ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    keys_valid_d = keys_valid_q;
    done_d       = 1'b0;
    for (int i = 0; i < NUM_RK; i++) rk_d[i] = rk_q[i];

    case (state_q)
      ST_IDLE, ST_READY: begin
        if (start) begin
          rk_d[0]      = key;
          cnt_d        = CNT_W'(1);
          state_d      = ST_EXPAND;
          busy_d       = 1'b1;
          keys_valid_d = 1'b0;
        end
      end
      ST_EXPAND: begin
        for (int i = 1; i < NUM_RK; i++) begin
          if (CNT_W'(i) == cnt_q) rk_d[i] = next_key;
        end
        if (cnt_q == LAST_CNT) begin
          state_d      = ST_READY;
          cnt_d        = '0;
          busy_d       = 1'b0;
          keys_valid_d = 1'b1;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      keys_valid_q <= keys_valid_d;
      done_q       <= done_d;
      for (int i = 0; i < NUM_RK; i++) rk_q[i] <= rk_d[i];
    end
  end

  // Read port: indices 11..15 return zero.
  always_comb begin
    rd_key = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (CNT_W'(i) == rd_round) rd_key = rk_q[i];
    end
  end

  assign busy       = busy_q;
  assign keys_valid = keys_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_jb_aes128_key_expander.sv
// Self-checking bench for jb_aes128_key_expander against a GF(2^8)-derived key-schedule model.
module tb_jb_aes128_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         keys_valid;
  logic         done;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  int tests = 0;
  int fails = 0;

  logic [7:0]   sref  [256];
  logic [127:0] model [11];

  int done_at, busy_cycles, done_count;

  always #5 clk = ~clk;

  jb_aes128_key_expander #(.NROUNDS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .busy       (busy),
    .keys_valid (keys_valid),
    .done       (done),
    .rd_round   (rd_round),
    .rd_key     (rd_key)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine transform.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sref[w[31:24]], sref[w[23:16]], sref[w[15:8]], sref[w[7:0]]};
  endfunction

  // Word-wise FIPS-197 KeyExpansion over w[0..43].
  task automatic compute_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Start pulse; returns at the negedge right after the sampling edge T.
  task automatic pulse_start(input logic [127:0] k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key   = rand128();
  endtask

  // Observes samples n=0..14 after edge T; optionally injects a start at n=inj_n.
  task automatic observe(input int inj_n, input logic [127:0] inj_key);
    done_at = -1; busy_cycles = 0; done_count = 0;
    for (int n = 0; n <= 14; n++) begin
      if (n > 0) @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_count++;
        if (done_at < 0) done_at = n;
      end
      if (n == inj_n)     begin start = 1'b1; key = inj_key; end
      if (n == inj_n + 1) begin start = 1'b0; key = rand128(); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key = '0; rd_round = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, keys_valid, done} !== 3'b000) begin
      fails++; $display("FAIL reset_outputs got=%b exp=000", {busy, keys_valid, done});
    end
    for (int i = 0; i < 16; i++) begin
      rd_round = 4'(i); #1;
      tests++;
      if (rd_key !== 128'h0) begin
        fails++; $display("FAIL reset_rd_key idx=%0d got=%h exp=0", i, rd_key);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fips();
    logic [127:0] k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    compute_model(k);
    pulse_start(k);
    observe(-10, '0);
    tests++;
    if (done_at !== 10) begin fails++; $display("FAIL fips_done_latency got=%0d exp=10", done_at); end
    tests++;
    if ({busy, keys_valid, done} !== 3'b010) begin
      fails++; $display("FAIL fips_ready_flags got=%b exp=010", {busy, keys_valid, done});
    end
    rd_round = 4'd0; #1; tests++;
    if (rd_key !== k) begin fails++; $display("FAIL fips_rk0 got=%h exp=%h", rd_key, k); end
    rd_round = 4'd1; #1; tests++;
    if (rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      fails++; $display("FAIL fips_rk1 got=%h exp=a0fafe1788542cb123a339392a6c7605", rd_key);
    end
    rd_round = 4'd10; #1; tests++;
    if (rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      fails++; $display("FAIL fips_rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", rd_key);
    end
    for (int i = 0; i < 11; i++) begin
      rd_round = 4'(i); #1; tests++;
      if (rd_key !== model[i]) begin fails++; $display("FAIL fips_sweep idx=%0d got=%h exp=%h", i, rd_key, model[i]); end
    end
  endtask

  task automatic test_zero_key();
    pulse_start(128'h0);
    observe(-10, '0);
    tests++;
    if (busy_cycles !== 10) begin fails++; $display("FAIL zero_busy_cycles got=%0d exp=10", busy_cycles); end
    tests++;
    if (done_at !== 10) begin fails++; $display("FAIL zero_done_latency got=%0d exp=10", done_at); end
    rd_round = 4'd1; #1; tests++;
    if (rd_key !== 128'h62636363626363636263636362636363) begin
      fails++; $display("FAIL zero_rk1 got=%h exp=62636363626363636263636362636363", rd_key);
    end
    rd_round = 4'd10; #1; tests++;
    if (rd_key !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      fails++; $display("FAIL zero_rk10 got=%h exp=b4ef5bcb3e92e21123e951cf6f8f188e", rd_key);
    end
  endtask

  task automatic test_ignored_start();
    logic [127:0] k1 = rand128();
    logic [127:0] k2 = rand128();
    compute_model(k1);
    pulse_start(k1);
    observe(4, k2);
    tests++;
    if (done_count !== 1) begin fails++; $display("FAIL ignored_done_count got=%0d exp=1", done_count); end
    tests++;
    if (done_at !== 10) begin fails++; $display("FAIL ignored_done_latency got=%0d exp=10", done_at); end
    for (int i = 0; i < 11; i++) begin
      rd_round = 4'(i); #1; tests++;
      if (rd_key !== model[i]) begin fails++; $display("FAIL ignored_sweep idx=%0d got=%h exp=%h", i, rd_key, model[i]); end
    end
  endtask

  task automatic test_restart();
    logic [127:0] k3 = rand128();
    logic kv_at [15];
    compute_model(k3);
    pulse_start(k3);
    for (int n = 0; n <= 14; n++) begin
      if (n > 0) @(negedge clk);
      kv_at[n] = keys_valid;
    end
    tests++;
    if (kv_at[0] !== 1'b0) begin fails++; $display("FAIL restart_kv_drop got=%b exp=0", kv_at[0]); end
    tests++;
    if (kv_at[9] !== 1'b0) begin fails++; $display("FAIL restart_kv_early got=%b exp=0", kv_at[9]); end
    tests++;
    if (kv_at[10] !== 1'b1) begin fails++; $display("FAIL restart_kv_rise got=%b exp=1", kv_at[10]); end
    for (int i = 0; i < 11; i++) begin
      rd_round = 4'(i); #1; tests++;
      if (rd_key !== model[i]) begin fails++; $display("FAIL restart_sweep idx=%0d got=%h exp=%h", i, rd_key, model[i]); end
    end
  endtask

  task automatic test_rst_mid();
    logic [127:0] k5 = rand128();
    pulse_start(rand128());
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    #1;
    tests++;
    if ({busy, keys_valid, done} !== 3'b000) begin
      fails++; $display("FAIL rstmid_outputs got=%b exp=000", {busy, keys_valid, done});
    end
    for (int i = 0; i < 16; i++) begin
      rd_round = 4'(i); #1; tests++;
      if (rd_key !== 128'h0) begin fails++; $display("FAIL rstmid_rd_key idx=%0d got=%h exp=0", i, rd_key); end
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_start_blocked got=%b exp=0", busy); end
    start = 1'b0; rst = 1'b0;
    compute_model(k5);
    pulse_start(k5);
    observe(-10, '0);
    tests++;
    if (done_at !== 10) begin fails++; $display("FAIL rstmid_fresh_latency got=%0d exp=10", done_at); end
    for (int i = 0; i < 11; i++) begin
      rd_round = 4'(i); #1; tests++;
      if (rd_key !== model[i]) begin fails++; $display("FAIL rstmid_sweep idx=%0d got=%h exp=%h", i, rd_key, model[i]); end
    end
  endtask

  task automatic test_random_sweep();
    for (int r = 0; r < 4; r++) begin
      logic [127:0] k = rand128();
      compute_model(k);
      pulse_start(k);
      observe(-10, '0);
      tests++;
      if (done_at !== 10) begin fails++; $display("FAIL rand_latency run=%0d got=%0d exp=10", r, done_at); end
      for (int i = 0; i < 16; i++) begin
        logic [127:0] exp_key = (i <= 10) ? model[i] : 128'h0;
        rd_round = 4'(i); #1; tests++;
        if (rd_key !== exp_key) begin fails++; $display("FAIL rand_sweep run=%0d idx=%0d got=%h exp=%h", r, i, rd_key, exp_key); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key = '0; rd_round = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_ignored_start();
    test_restart();
    test_rst_mid();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
